// File: rtl/out_byte_uart_tx.sv
// out_byte_uart_tx: buffers CPU output-port bytes in a FIFO and sends them as UART frames.
// Latency: a byte_en into an empty FIFO with the line idle drives the start bit two cycles later.
// Backpressure: none toward the CPU; a byte arriving while the FIFO is full is dropped and
//   latches the sticky overflow flag.
//
// Ports:
//   clk        rising-edge system clock
//   reset_i    synchronous active-high reset
//   byte_in    byte from the CPU output port
//   byte_en    one-cycle strobe qualifying byte_in
//   ovf_clr    clears the sticky overflow flag (a drop in the same cycle wins)
//   tx         registered UART line, idle high
//   busy       frame in flight or FIFO non-empty
//   fifo_full  FIFO holds FIFO_DEPTH entries
//   fifo_count number of FIFO entries
//   overflow   sticky "a byte was dropped"
//
// Optional build macro OUT_BYTE_UART_PARITY_EN adds an even-parity bit (8E1); default is 8N1.
module out_byte_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic [7:0]       byte_in,
  input  logic             byte_en,
  input  logic             ovf_clr,
  output logic             tx,
  output logic             busy,
  output logic             fifo_full,
  output logic [FIFO_AW:0] fifo_count,
  output logic             overflow
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef OUT_BYTE_UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] DEPTH     = (FIFO_AW + 1)'(FIFO_DEPTH);

  // FIFO storage and bookkeeping
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  // Serialiser state
  logic [2:0]  state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] baud_q, baud_d;
  logic        tx_q, tx_d;
`ifdef OUT_BYTE_UART_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic       push, drop, pop, baud_end;
  logic [7:0] rd_data;

  assign rd_data  = mem_q[rd_ptr_q];
  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    push = byte_en && !fifo_full;
    // A full FIFO drops the byte even if the serialiser pops this cycle:
    // fullness is judged on the registered count only.
    drop = byte_en && fifo_full;
    pop  = (state_q == S_IDLE) && (count_q != '0);

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);

    // Set has priority over clear so a drop is never lost.
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // tx_d is the line level for the state being entered, so tx comes straight
  // from a flop and changes exactly on the state/bit boundary.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_end ? 16'd0 : baud_q + 16'd1;
    tx_d      = tx_q;
`ifdef OUT_BYTE_UART_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        baud_d = 16'd0;
        tx_d   = 1'b1;
        if (pop) begin
          shift_d   = rd_data;
          bit_cnt_d = 3'd0;
          state_d   = S_START;
          tx_d      = 1'b0;
`ifdef OUT_BYTE_UART_PARITY_EN
          parity_d  = ^rd_data;
`endif
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (baud_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (baud_end) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef OUT_BYTE_UART_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[1];   // next bit after the shift
          end
        end
      end
`ifdef OUT_BYTE_UART_PARITY_EN
      S_PARITY: begin
        tx_d = parity_q;
        if (baud_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = 16'd0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= S_IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      baud_q    <= 16'd0;
      tx_q      <= 1'b1;
`ifdef OUT_BYTE_UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      baud_q    <= baud_d;
      tx_q      <= tx_d;
`ifdef OUT_BYTE_UART_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= byte_in;
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_full  = (count_q == DEPTH);
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_out_byte_uart_tx.sv
// tb_out_byte_uart_tx: directed scenarios for out_byte_uart_tx with a frame-decoding line monitor.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_out_byte_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef OUT_BYTE_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FCYC = NBITS * CPB;

  logic          clk = 1'b0;
  logic          reset_i, byte_en, ovf_clr;
  logic [7:0]    byte_in;
  logic          tx, busy, fifo_full, overflow;
  logic [AW:0]   fifo_count;

  out_byte_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .clk(clk), .reset_i(reset_i), .byte_in(byte_in), .byte_en(byte_en), .ovf_clr(ovf_clr),
    .tx(tx), .busy(busy), .fifo_full(fifo_full), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;
  int rxi    = 0;

  // Line monitor: a frame begins at the first low sample; every bit must hold
  // for CPB samples, start=0, stop=1 (and even parity when enabled).
  logic [7:0]       rx_byte[$];
  logic             rx_ok[$];
  logic             rx_par[$];
  int               rx_start[$];
  logic             in_frame = 1'b0;
  int               smp = 0;
  int               f_start = 0;
  logic [FCYC-1:0]  samp;
  logic [NBITS-1:0] fbits;
  logic             dec_ok;

  always @(negedge clk) begin
    if (reset_i === 1'b1) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx === 1'b0) begin
        in_frame = 1'b1;
        smp      = 0;
        f_start  = cyc;
      end
      if (in_frame) begin
        samp[smp] = tx;
        smp++;
        if (smp == FCYC) begin
          dec_ok = 1'b1;
          for (int j = 0; j < NBITS; j++) begin
            fbits[j] = samp[j*CPB];
            for (int k = 1; k < CPB; k++)
              if (samp[j*CPB+k] !== samp[j*CPB]) dec_ok = 1'b0;
          end
          if (fbits[0] !== 1'b0 || fbits[NBITS-1] !== 1'b1) dec_ok = 1'b0;
`ifdef OUT_BYTE_UART_PARITY_EN
          if (fbits[9] !== ^fbits[8:1]) dec_ok = 1'b0;
          rx_par.push_back(fbits[9]);
`else
          rx_par.push_back(1'b0);
`endif
          rx_byte.push_back(fbits[8:1]);
          rx_ok.push_back(dec_ok);
          rx_start.push_back(f_start);
          in_frame = 1'b0;
        end
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t = 0;
    while (rx_byte.size() < rxi + n && t < budget) begin
      tick;
      t++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (busy !== 1'b0 && t < budget) begin
      tick;
      t++;
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b1; byte_en = 1'b0; ovf_clr = 1'b0; byte_in = 8'h00;
    repeat (3) tick;
    n_chk++; if (tx !== 1'b1)        $display("FAIL reset_tx: got %b want 1", tx);               else n_pass++;
    n_chk++; if (busy !== 1'b0)      $display("FAIL reset_busy: got %b want 0", busy);           else n_pass++;
    n_chk++; if (fifo_full !== 1'b0) $display("FAIL reset_full: got %b want 0", fifo_full);      else n_pass++;
    n_chk++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", fifo_count);  else n_pass++;
    n_chk++; if (overflow !== 1'b0)  $display("FAIL reset_ovf: got %b want 0", overflow);        else n_pass++;
    reset_i = 1'b0;
    tick;
  endtask

  task automatic test_single;
    int fall;
    byte_in = 8'h55; byte_en = 1'b1;
    tick;                                  // cycle N+1
    byte_en = 1'b0;
    n_chk++; if (tx !== 1'b1 || fifo_count !== 3'd1)
      $display("FAIL single_n1: got tx=%b count=%0d want tx=1 count=1", tx, fifo_count); else n_pass++;
    tick;                                  // cycle N+2: start bit
    n_chk++; if (tx !== 1'b0) $display("FAIL single_latency: got tx=%b want 0", tx); else n_pass++;
    wait_rx(1, 100);
    n_chk++;
    if (rx_byte.size() < rxi + 1) $display("FAIL single_frame: got %0d frames want 1", rx_byte.size() - rxi);
    else if (rx_byte[rxi] !== 8'h55 || rx_ok[rxi] !== 1'b1)
      $display("FAIL single_frame: got %h ok=%b want 55 ok=1", rx_byte[rxi], rx_ok[rxi]);
    else n_pass++;
    wait_idle(100);
    fall = (rx_byte.size() > rxi) ? cyc - rx_start[rxi] : -1;
    n_chk++; if (busy !== 1'b0 || fall != FCYC || fifo_count !== 3'd0)
      $display("FAIL single_busy_fall: got busy=%b after %0d cycles count=%0d want busy=0 after %0d count=0",
               busy, fall, fifo_count, FCYC);
    else n_pass++;
    rxi = rx_byte.size();
  endtask

  task automatic test_back_to_back;
    int peak = 0;
    int t = 0;
    logic [7:0] exp_b [3] = '{8'h41, 8'h42, 8'h43};
    byte_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      byte_in = exp_b[i];
      tick;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    byte_en = 1'b0;
    while (rx_byte.size() < rxi + 3 && t < 300) begin
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      tick;
      t++;
    end
    n_chk++; if (rx_byte.size() < rxi + 3)
      $display("FAIL b2b_frames: got %0d frames want 3", rx_byte.size() - rxi); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (rx_byte.size() <= rxi + i) $display("FAIL b2b_data%0d: got no frame want %h", i, exp_b[i]);
      else if (rx_byte[rxi+i] !== exp_b[i] || rx_ok[rxi+i] !== 1'b1)
        $display("FAIL b2b_data%0d: got %h ok=%b want %h ok=1", i, rx_byte[rxi+i], rx_ok[rxi+i], exp_b[i]);
      else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (rx_start.size() <= rxi + i + 1) $display("FAIL b2b_gap%0d: frame missing", i);
      else if (rx_start[rxi+i+1] - rx_start[rxi+i] != FCYC + 1)
        $display("FAIL b2b_gap%0d: got %0d want %0d", i, rx_start[rxi+i+1] - rx_start[rxi+i], FCYC + 1);
      else n_pass++;
    end
    n_chk++; if (peak != 2) $display("FAIL b2b_peak: got %0d want 2", peak); else n_pass++;
    wait_idle(100);
    rxi = rx_byte.size();
  endtask

  task automatic test_overflow;
    byte_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      byte_in = 8'h10 + 8'(i);
      tick;
    end
    byte_en = 1'b0;
    n_chk++; if (overflow !== 1'b1 || fifo_full !== 1'b1 || fifo_count !== 3'd4)
      $display("FAIL ovf_state: got ovf=%b full=%b count=%0d want 1 1 4", overflow, fifo_full, fifo_count);
    else n_pass++;
    wait_rx(5, 5 * (FCYC + 1) + 50);
    wait_idle(100);
    n_chk++; if (rx_byte.size() != rxi + 5)
      $display("FAIL ovf_nframes: got %0d want 5", rx_byte.size() - rxi); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (rx_byte.size() <= rxi + i) $display("FAIL ovf_data%0d: got no frame want %h", i, 8'h10 + 8'(i));
      else if (rx_byte[rxi+i] !== 8'h10 + 8'(i) || rx_ok[rxi+i] !== 1'b1)
        $display("FAIL ovf_data%0d: got %h ok=%b want %h", i, rx_byte[rxi+i], rx_ok[rxi+i], 8'h10 + 8'(i));
      else n_pass++;
    end
    n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    n_chk++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else n_pass++;
    rxi = rx_byte.size();
  endtask

  task automatic test_drop_on_pop;
    int c0 = cyc;
    int t = 0;
    byte_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      byte_in = 8'h20 + 8'(i);
      tick;
    end
    byte_en = 1'b0;
    // First frame starts at c0+2; the single IDLE pop cycle follows it.
    while (cyc < c0 + 2 + FCYC && t < 200) begin
      tick;
      t++;
    end
    n_chk++; if (fifo_full !== 1'b1 || fifo_count !== 3'd4 || overflow !== 1'b0)
      $display("FAIL pop_pre: got full=%b count=%0d ovf=%b want 1 4 0", fifo_full, fifo_count, overflow);
    else n_pass++;
    byte_in = 8'h99; byte_en = 1'b1;
    tick;
    byte_en = 1'b0;
    // Only the pop takes effect: count 4 -> 3, the strobed byte is lost.
    n_chk++; if (overflow !== 1'b1 || fifo_count !== 3'd3)
      $display("FAIL pop_drop: got ovf=%b count=%0d want ovf=1 count=3", overflow, fifo_count);
    else n_pass++;
    wait_rx(5, 5 * (FCYC + 1) + 50);
    wait_idle(100);
    n_chk++; if (rx_byte.size() != rxi + 5)
      $display("FAIL pop_nframes: got %0d want 5", rx_byte.size() - rxi); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (rx_byte.size() <= rxi + i) $display("FAIL pop_data%0d: got no frame want %h", i, 8'h20 + 8'(i));
      else if (rx_byte[rxi+i] !== 8'h20 + 8'(i) || rx_ok[rxi+i] !== 1'b1)
        $display("FAIL pop_data%0d: got %h ok=%b want %h", i, rx_byte[rxi+i], rx_ok[rxi+i], 8'h20 + 8'(i));
      else n_pass++;
    end
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    rxi = rx_byte.size();
  endtask

  task automatic test_reset_mid;
    int c0 = cyc;
    int t = 0;
    logic stayed_high = 1'b1;
    byte_en = 1'b1;
    byte_in = 8'hA5; tick;
    byte_in = 8'hB1; tick;
    byte_in = 8'hB2; tick;
    byte_en = 1'b0;
    n_chk++; if (fifo_count !== 3'd2) $display("FAIL rstmid_queued: got %0d want 2", fifo_count); else n_pass++;
    // Data bit 3 occupies frame cycles 16..19, i.e. c0+18..c0+21.
    while (cyc < c0 + 19 && t < 100) begin
      tick;
      t++;
    end
    n_chk++; if (tx !== 1'b0) $display("FAIL rstmid_bit3: got tx=%b want 0", tx); else n_pass++;
    reset_i = 1'b1;
    tick;
    n_chk++; if (tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0)
      $display("FAIL rstmid_after: got tx=%b count=%0d busy=%b want 1 0 0", tx, fifo_count, busy);
    else n_pass++;
    reset_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (tx !== 1'b1) stayed_high = 1'b0;
    end
    n_chk++; if (stayed_high !== 1'b1 || rx_byte.size() != rxi || busy !== 1'b0)
      $display("FAIL rstmid_quiet: got high=%b frames=%0d busy=%b want 1 0 0", stayed_high, rx_byte.size() - rxi, busy);
    else n_pass++;
  endtask

`ifdef OUT_BYTE_UART_PARITY_EN
  task automatic test_parity;
    logic [7:0] vals [2] = '{8'h07, 8'h03};
    logic       pars [2] = '{1'b1, 1'b0};
    int fall;
    for (int i = 0; i < 2; i++) begin
      byte_in = vals[i]; byte_en = 1'b1;
      tick;
      byte_en = 1'b0;
      wait_rx(1, 100);
      n_chk++;
      if (rx_byte.size() <= rxi) $display("FAIL parity%0d: got no frame want %h", i, vals[i]);
      else if (rx_byte[rxi] !== vals[i] || rx_par[rxi] !== pars[i] || rx_ok[rxi] !== 1'b1)
        $display("FAIL parity%0d: got %h par=%b ok=%b want %h par=%b ok=1",
                 i, rx_byte[rxi], rx_par[rxi], rx_ok[rxi], vals[i], pars[i]);
      else n_pass++;
      wait_idle(100);
      fall = (rx_byte.size() > rxi) ? cyc - rx_start[rxi] : -1;
      n_chk++; if (fall != 44) $display("FAIL parity_len%0d: got %0d want 44", i, fall); else n_pass++;
      rxi = rx_byte.size();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks so far %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_drop_on_pop;
`ifdef OUT_BYTE_UART_PARITY_EN
    test_parity;
`endif
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
